// File: rtl/day10_pkg.sv
// Shared types and constants for the Day 10 machine-description parser.
package day10_pkg;

  typedef enum logic [2:0] {
    SEEK_LIGHTS,
    LIGHTS,
    SEEK_GROUP,
    BUTTON_IDX,
    SKIP_EOL,
    HOLD
  } state_t;

  localparam logic [7:0] CH_LBRACK = 8'h5B;  // [
  localparam logic [7:0] CH_RBRACK = 8'h5D;  // ]
  localparam logic [7:0] CH_LPAREN = 8'h28;  // (
  localparam logic [7:0] CH_RPAREN = 8'h29;  // )
  localparam logic [7:0] CH_LBRACE = 8'h7B;  // {
  localparam logic [7:0] CH_COMMA  = 8'h2C;  // ,
  localparam logic [7:0] CH_HASH   = 8'h23;  // #
  localparam logic [7:0] CH_DOT    = 8'h2E;  // .
  localparam logic [7:0] CH_NL     = 8'h0A;  // \n
  localparam logic [7:0] CH_0      = 8'h30;  // 0
  localparam logic [7:0] CH_9      = 8'h39;  // 9

  // Bits needed to hold a count in 0..n.
  function automatic int count_w(int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

  // The button index accumulator carries 4 extra bits so a two-digit index
  // out of range is still representable before it saturates.
  function automatic int acc_w(int max_lights);
    return count_w(max_lights) + 4;
  endfunction

endpackage

// File: rtl/day10_machine_parser_acc.sv
// Saturating decimal accumulator: value = value*10 + digit per strobe.
module ascii_decimal_accumulator #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         digit_vld,
  input  logic [3:0]   digit,
  output logic [W-1:0] value
);

  localparam int PW = W + 4;

  // value*10+9 < 16*2^W, so PW bits never overflow before the saturation test.
  logic [PW-1:0] prod;
  assign prod = (PW'(value) << 3) + (PW'(value) << 1) + PW'(digit);

  always_ff @(posedge clk) begin
    if (!rst_n || clear)
      value <= '0;
    else if (digit_vld)
      value <= (|prod[PW-1:W]) ? '1 : prod[W-1:0];
  end

endmodule

// File: rtl/day10_machine_parser.sv
// Parses one Day 10 machine line per description and holds it until accepted.
// Optional DAY10_PARSE_ERROR_EN adds a sticky parse_error output.
module day10_machine_parser
  import day10_pkg::*;
#(
  parameter int MAX_NUM_LIGHTS    = 10,
  parameter int MAX_NUM_BUTTONS   = 13,
  parameter int MAX_NUM_LIGHTS_W  = count_w(MAX_NUM_LIGHTS),
  parameter int MAX_NUM_BUTTONS_W = count_w(MAX_NUM_BUTTONS),
  parameter int AXI_DATA_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI_DATA_WIDTH-1:0]     char_tdata,
  input  logic                          char_tvalid,
  output logic                          char_tready,
  input  logic                          char_tlast,
  output logic [MAX_NUM_LIGHTS_W-1:0]   num_lights,
  output logic [MAX_NUM_LIGHTS-1:0]     target_lights_arrangement,
  output logic [MAX_NUM_BUTTONS_W-1:0]  num_buttons,
  output logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] buttons,
  output logic                          machine_valid,
  output logic                          machine_last,
  input  logic                          machine_accept,
  output logic [15:0]                   lines_parsed
`ifdef DAY10_PARSE_ERROR_EN
  ,
  output logic                          parse_error
`endif
);

  localparam int ACC_W = acc_w(MAX_NUM_LIGHTS);
  localparam logic [MAX_NUM_LIGHTS-1:0] ONE_HOT0 = 1;

  state_t state, state_n;
  logic [MAX_NUM_LIGHTS_W-1:0]  num_lights_n;
  logic [MAX_NUM_LIGHTS-1:0]    target_n;
  logic [MAX_NUM_BUTTONS_W-1:0] num_buttons_n;
  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] buttons_n;
  logic last_n, have_digit, have_digit_n;
  logic acc_clr, acc_dig, set_bit, err_set, err_clr;
  logic [ACC_W-1:0] acc_val;
  logic [7:0] ch;
  logic fire, is_digit, lights_room, buttons_room, idx_ok;

  assign ch           = char_tdata[7:0];
  assign char_tready  = rst_n && (state != HOLD);
  assign fire         = char_tvalid && char_tready;
  assign is_digit     = (ch >= CH_0) && (ch <= CH_9);
  assign lights_room  = num_lights < MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS);
  assign buttons_room = num_buttons < MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS);
  assign idx_ok       = acc_val < ACC_W'(num_lights);
  assign machine_valid = (state == HOLD);

  ascii_decimal_accumulator #(.W(ACC_W)) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (acc_clr),
    .digit_vld (acc_dig),
    .digit     (ch[3:0]),
    .value     (acc_val)
  );

  always_comb begin
    state_n       = state;
    num_lights_n  = num_lights;
    target_n      = target_lights_arrangement;
    num_buttons_n = num_buttons;
    buttons_n     = buttons;
    last_n        = machine_last;
    have_digit_n  = have_digit;
    acc_clr       = 1'b0;
    acc_dig       = 1'b0;
    set_bit       = 1'b0;
    err_set       = 1'b0;
    err_clr       = 1'b0;
    if (state == HOLD) begin
      if (machine_accept) state_n = SEEK_LIGHTS;
    end else if (fire) begin
      case (state)
        SEEK_LIGHTS: if (ch == CH_LBRACK) begin
          num_lights_n  = '0;
          target_n      = '0;
          num_buttons_n = '0;
          buttons_n     = '0;
          last_n        = 1'b0;
          acc_clr       = 1'b1;
          err_clr       = 1'b1;
          state_n       = LIGHTS;
        end
        LIGHTS: begin
          if (ch == CH_DOT || ch == CH_HASH) begin
            if (lights_room) begin
              if (ch == CH_HASH) target_n = target_lights_arrangement | (ONE_HOT0 << num_lights);
              num_lights_n = num_lights + MAX_NUM_LIGHTS_W'(1);
            end else begin
              err_set = 1'b1;
            end
          end else if (ch == CH_RBRACK) begin
            state_n = SEEK_GROUP;
          end else begin
            err_set = 1'b1;
          end
        end
        SEEK_GROUP: begin
          if (ch == CH_LPAREN) begin
            acc_clr      = 1'b1;
            have_digit_n = 1'b0;
            state_n      = BUTTON_IDX;
          end else if (ch == CH_LBRACE) begin
            state_n = SKIP_EOL;
          end else if (ch == CH_NL) begin
            state_n = HOLD;
          end
        end
        BUTTON_IDX: begin
          if (is_digit) begin
            acc_dig      = 1'b1;
            have_digit_n = 1'b1;
          end else if (ch == CH_COMMA || ch == CH_RPAREN) begin
            // "()" carries no index, so only a seen digit may set a bit.
            if (have_digit) begin
              if (idx_ok && buttons_room) set_bit = 1'b1;
              else                        err_set = 1'b1;
            end
            acc_clr      = 1'b1;
            have_digit_n = 1'b0;
            if (ch == CH_RPAREN) begin
              if (buttons_room) num_buttons_n = num_buttons + MAX_NUM_BUTTONS_W'(1);
              else              err_set = 1'b1;
              state_n = SEEK_GROUP;
            end
          end else begin
            err_set = 1'b1;
          end
        end
        SKIP_EOL: if (ch == CH_NL) state_n = HOLD;
        default: ;
      endcase
      if (char_tlast) begin
        state_n = HOLD;
        last_n  = 1'b1;
      end
    end
    for (int b = 0; b < MAX_NUM_BUTTONS; b++)
      if (set_bit && b == int'(num_buttons))
        buttons_n[b] = buttons[b] | (ONE_HOT0 << acc_val);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                     <= SEEK_LIGHTS;
      num_lights                <= '0;
      target_lights_arrangement <= '0;
      num_buttons               <= '0;
      buttons                   <= '0;
      machine_last              <= 1'b0;
      have_digit                <= 1'b0;
      lines_parsed              <= '0;
    end else begin
      state                     <= state_n;
      num_lights                <= num_lights_n;
      target_lights_arrangement <= target_n;
      num_buttons               <= num_buttons_n;
      buttons                   <= buttons_n;
      machine_last              <= last_n;
      have_digit                <= have_digit_n;
      if (state == HOLD && machine_accept) lines_parsed <= lines_parsed + 16'd1;
    end
  end

`ifdef DAY10_PARSE_ERROR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)       parse_error <= 1'b0;
    else if (err_clr) parse_error <= 1'b0;
    else if (err_set) parse_error <= 1'b1;
  end
`else
  logic unused_err;
  assign unused_err = err_set | err_clr;
`endif

endmodule

// File: tb/tb_day10_machine_parser.sv
// Scoreboard bench for day10_machine_parser: expectations queued per line sent.
module tb_day10_machine_parser;

  typedef logic [159:0] w_t;
  typedef struct {
    int              nl;
    logic [9:0]      tgt;
    int              nb;
    logic [12:0][9:0] btn;
    logic            last;
    logic            err;
    int              hold;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] char_tdata;
  logic char_tvalid, char_tready, char_tlast;
  logic [3:0] num_lights, num_buttons;
  logic [9:0] target_lights_arrangement;
  logic [12:0][9:0] buttons;
  logic machine_valid, machine_last, machine_accept;
  logic [15:0] lines_parsed;
`ifdef DAY10_PARSE_ERROR_EN
  logic parse_error;
`endif

  int n_vec = 0, n_miss = 0, lp_exp = 0;
  bit busy = 0;
  exp_t sb[$];
  exp_t ce, e;

  always #5 clk = ~clk;

  day10_machine_parser dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .char_tdata                (char_tdata),
    .char_tvalid               (char_tvalid),
    .char_tready               (char_tready),
    .char_tlast                (char_tlast),
    .num_lights                (num_lights),
    .target_lights_arrangement (target_lights_arrangement),
    .num_buttons               (num_buttons),
    .buttons                   (buttons),
    .machine_valid             (machine_valid),
    .machine_last              (machine_last),
    .machine_accept            (machine_accept),
    .lines_parsed              (lines_parsed)
`ifdef DAY10_PARSE_ERROR_EN
    ,
    .parse_error               (parse_error)
`endif
  );

  task automatic chk(input string tag, input w_t got, input w_t exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(int nl, logic [9:0] tgt, int nb, logic last, logic err, int hold);
    exp_t r;
    r.nl = nl; r.tgt = tgt; r.nb = nb; r.btn = '0;
    r.last = last; r.err = err; r.hold = hold;
    return r;
  endfunction

  function automatic exp_t line1_exp(int hold);
    exp_t r;
    r = mk(4, 10'b0110, 6, 1'b0, 1'b0, hold);
    r.btn[0] = 10'b1000; r.btn[1] = 10'b1010; r.btn[2] = 10'b0100;
    r.btn[3] = 10'b1100; r.btn[4] = 10'b0101; r.btn[5] = 10'b0011;
    return r;
  endfunction

  function automatic w_t pack_dut();
    return w_t'({num_buttons, num_lights, target_lights_arrangement, buttons});
  endfunction

  function automatic w_t pack_exp(exp_t x);
    return w_t'({4'(x.nb), 4'(x.nl), x.tgt, x.btn});
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap_pct);
    int t;
    @(negedge clk);
    while ($urandom_range(99) < gap_pct) begin
      char_tvalid = 1'b0;
      @(negedge clk);
    end
    char_tdata = b; char_tlast = last; char_tvalid = 1'b1;
    t = 0;
    while (!char_tready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      chk("tready_timeout", 1, 0);
      char_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 char_tvalid = 1'b0; char_tlast = 1'b0;
  endtask

  task automatic send_line(input string s, input bit tlast_end, input int gap_pct);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], tlast_end && (i == s.len() - 1), gap_pct);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || machine_valid || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", w_t'(sb.size()), 0);
  endtask

  // Consumer: compare on valid, hold for the queued delay, then accept.
  initial begin
    machine_accept = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && machine_valid) begin
        busy = 1;
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          ce = sb.pop_front();
          chk("num_lights", w_t'(num_lights), w_t'(ce.nl));
          chk("target", w_t'(target_lights_arrangement), w_t'(ce.tgt));
          chk("num_buttons", w_t'(num_buttons), w_t'(ce.nb));
          chk("buttons", w_t'(buttons), w_t'(ce.btn));
          chk("machine_last", w_t'(machine_last), w_t'(ce.last));
`ifdef DAY10_PARSE_ERROR_EN
          chk("parse_error", w_t'(parse_error), w_t'(ce.err));
`endif
          for (int i = 0; i < ce.hold; i++) begin
            @(negedge clk);
            chk("hold_tready", w_t'(char_tready), 0);
            chk("hold_valid", w_t'(machine_valid), 1);
            chk("hold_stable", pack_dut(), pack_exp(ce));
          end
        end
        machine_accept = 1'b1;
        @(negedge clk);
        machine_accept = 1'b0;
        lp_exp++;
        chk("valid_clr", w_t'(machine_valid), 0);
        chk("lines_parsed", w_t'(lines_parsed), w_t'(lp_exp));
        busy = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; char_tvalid = 1'b0; char_tlast = 1'b0; char_tdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tready", w_t'(char_tready), 0);
    chk("rst_valid", w_t'(machine_valid), 0);
    chk("rst_last", w_t'(machine_last), 0);
    chk("rst_lines", w_t'(lines_parsed), 0);
    chk("rst_fields", pack_dut(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_rst", w_t'(char_tready), 1);

    // Empty line: nothing may be emitted (consumer flags sb_empty otherwise).
    send_line("\n", 0, 0);
    repeat (3) @(negedge clk);
    chk("empty_line_valid", w_t'(machine_valid), 0);

    sb.push_back(line1_exp(0));
    send_line("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", 0, 0);
    wait_idle();

    e = mk(10, 10'b0, 1, 1'b0, 1'b1, 0);
    e.btn[0] = 10'b1;
    sb.push_back(e);
    send_line("[...........] (10,0)\n", 0, 0);
    wait_idle();

    // Backpressure: first description held for 20 cycles while more lines queue.
    sb.push_back(line1_exp(20));
    e = mk(3, 10'b101, 2, 1'b0, 1'b0, 0);
    e.btn[0] = 10'b001; e.btn[1] = 10'b110;
    sb.push_back(e);
    sb.push_back(mk(2, 10'b11, 1, 1'b0, 1'b0, 3));
    send_line("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", 0, 0);
    send_line("[#.#] (0) (1,2)\n", 0, 0);
    send_line("[##] ()\n", 0, 0);
    wait_idle();

    e = mk(2, 10'b10, 1, 1'b1, 1'b0, 2);
    e.btn[0] = 10'b10;
    sb.push_back(e);
    send_line("[.#] (1) {5}", 1, 0);
    chk("tlast_valid", w_t'(machine_valid), 1);
    chk("tlast_tready", w_t'(char_tready), 0);
    wait_idle();

    sb.push_back(line1_exp(0));
    send_line("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", 0, 50);
    wait_idle();

    // Reset in the middle of a button index.
    send_line("[.#] (1", 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midrst_tready", w_t'(char_tready), 0);
    @(negedge clk);
    chk("midrst_fields", pack_dut(), 0);
    chk("midrst_valid", w_t'(machine_valid), 0);
    chk("midrst_lines", w_t'(lines_parsed), 0);
    lp_exp = 0;
    rst_n = 1'b1;
    sb.push_back(line1_exp(0));
    send_line("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", 0, 0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
